corner_frame_seq: RTL and testbench

//  Per-frame sequencer downstream of the corner-detection FSM.
//  - Tracks VGA_VS frame boundaries and waits for the detector's corner outputs to settle.
//  - Captures the 8 corner coordinates and checks them against the previous frame for stability.
//  - Presents each frame's corners to the HPS/render consumer over a valid/ready handshake,

---
 rtl/corner_frame_seq.sv | 193 +++++++++++++++++++
 tb/tb_corner_frame_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/corner_frame_seq.sv
// ---------------------------------------------------------------------------
// corner_frame_seq
//   Per-frame sequencer sitting after the corner-detection FSM. On each
//   falling edge of VGA_VS it waits for the detector outputs to settle,
//   captures the eight corner coordinates, and compares them with the
//   previous frame. A frame whose corners all match the previous frame
//   within JITTER advances a stability counter. When that counter reaches
//   STABLE_FRAMES, locked is raised. Each captured frame is then offered
//   to the consumer over a valid/ready output.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   enable       run the sequencer; low forces IDLE and clears status
//   VGA_VS       vertical sync, same clock domain as clk
//   corners_in   {tl_x,tl_y,tr_x,tr_y,bl_x,bl_y,br_x,br_y}, 10b unsigned each
//   out_ready    consumer accepts corners_out
//   corners_out  captured corners, same packing as corners_in
//   out_valid    corners_out holds a frame the consumer has not taken yet
//   locked       stability counter has reached STABLE_FRAMES
//   overrun      sticky: a frame the consumer had not taken was overwritten
//   frame_count  number of frames presented since reset; wraps
//   dbg_state    current FSM state, for observation
//
// Output handshake: a transfer happens in any cycle where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// corners_out holds its value. out_valid drops in the cycle after a
// transfer, unless a new frame is presented in that same cycle.
// ---------------------------------------------------------------------------
module corner_frame_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int JITTER        = 4,
    parameter int STABLE_FRAMES = 8,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   VGA_VS,
    input  logic [79:0]            corners_in,
    input  logic                   out_ready,
    output logic [79:0]            corners_out,
    output logic                   out_valid,
    output logic                   locked,
    output logic                   overrun,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [2:0]             dbg_state
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SC_W  = $clog2(STABLE_FRAMES + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SC_W-1:0]  STABLE_MAX  = SC_W'(STABLE_FRAMES);
    localparam logic [10:0]      JITTER_11   = 11'(JITTER);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_VS = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_COMPARE = 3'd4,
        S_PRESENT = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             vs_prev;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [79:0]      cur;
    logic [79:0]      prev;
    logic             prev_valid;
    logic [SC_W-1:0]  stable_cnt;
    logic [SC_W-1:0]  stable_nxt;
    logic             all_match;
    logic             xfer;

    assign fall      = vs_prev & ~VGA_VS;
    assign xfer      = out_valid & out_ready;
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. Falls seen outside WAIT_VS are dropped on purpose:
    // the sequencer handles one frame at a time and does not queue them.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (enable) state_nxt = S_WAIT_VS;
            S_WAIT_VS: if (fall) state_nxt = S_SETTLE;
            S_SETTLE:  if (cnt == '0) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = S_PRESENT;
            S_PRESENT: state_nxt = S_WAIT_VS;
            default:   state_nxt = S_IDLE;
        endcase
        if (!enable) state_nxt = S_IDLE;
    end

    // ------------------------------------------------------------------
    // Stability compare. Each coordinate difference is taken as an
    // 11-bit signed value, so the full 10-bit range is covered without
    // wrap. An all-zero capture means the detector has cleared its
    // outputs, so such a frame never counts as a match.
    // ------------------------------------------------------------------
    always_comb begin
        all_match = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [10:0] diff;
            logic [10:0] absd;
            diff = {1'b0, cur[i*10 +: 10]} - {1'b0, prev[i*10 +: 10]};
            absd = diff[10] ? (11'd0 - diff) : diff;
            if (absd > JITTER_11) all_match = 1'b0;
        end

        stable_nxt = '0;
        if (all_match && prev_valid && (cur != '0)) begin
            stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev     <= 1'b0;
            cnt         <= '0;
            cur         <= '0;
            prev        <= '0;
            prev_valid  <= 1'b0;
            stable_cnt  <= '0;
            locked      <= 1'b0;
            overrun     <= 1'b0;
            out_valid   <= 1'b0;
            corners_out <= '0;
            frame_count <= '0;
        end else begin
            vs_prev <= VGA_VS;

            if (!enable) begin
                // frame_count and corners_out are kept on purpose, so the
                // consumer still sees the last frame after a pause.
                out_valid  <= 1'b0;
                stable_cnt <= '0;
                prev_valid <= 1'b0;
                locked     <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                if (state == S_WAIT_VS && fall) begin
                    cnt <= SETTLE_LOAD;
                end else if (state == S_SETTLE && cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end

                if (state == S_CAPTURE) begin
                    cur <= corners_in;
                end

                if (state == S_COMPARE) begin
                    stable_cnt <= stable_nxt;
                    locked     <= (stable_nxt == STABLE_MAX);
                    prev       <= cur;
                    prev_valid <= 1'b1;
                end

                if (state == S_PRESENT) begin
                    // A frame still pending without a transfer this cycle
                    // is lost, and that loss is recorded in overrun.
                    corners_out <= cur;
                    out_valid   <= 1'b1;
                    frame_count <= frame_count + 1'b1;
                    if (out_valid && !out_ready) overrun <= 1'b1;
                end else if (xfer) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_corner_frame_seq.sv
module tb_corner_frame_seq;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        VGA_VS;
  logic [79:0] corners_in;
  logic        out_ready;
  logic [79:0] corners_out;
  logic        out_valid;
  logic        locked;
  logic        overrun;
  logic [15:0] frame_count;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // {locked, corners} expected at each transfer
  logic [80:0] exp_q[$];
  logic [15:0] exp_fc;

  typedef struct {
    logic [79:0] c;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[11];

  corner_frame_seq dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .VGA_VS      (VGA_VS),
    .corners_in  (corners_in),
    .out_ready   (out_ready),
    .corners_out (corners_out),
    .out_valid   (out_valid),
    .locked      (locked),
    .overrun     (overrun),
    .frame_count (frame_count),
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [9:0] a, b, c, d, e, f, g, h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one VS pulse; returns two cycles after the frame's transfer cycle
  task automatic do_frame(input logic [79:0] c);
    corners_in = c;
    VGA_VS = 1'b1;
    tick();
    tick();
    VGA_VS = 1'b0;
    repeat (8) tick();
  endtask

  // scoreboard: pop on every transfer
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL xfer_unexpected: got %0h, expected no transfer", corners_out);
      end else begin
        logic [80:0] e;
        e = exp_q.pop_front();
        check("xfer_corners", 128'(corners_out), 128'(e[79:0]));
        check("xfer_locked", 128'(locked), 128'(e[80]));
      end
    end
  end

  logic [79:0] base, fa, fb, fy, fz, fx, fw;

  initial begin
    base = mk(10'd100, 10'd50, 10'd500, 10'd60, 10'd110, 10'd400, 10'd520, 10'd410);
    // consecutive frames differ by at most 4 per coordinate, both directions
    vecs[0]  = '{base, 1'b0};
    vecs[1]  = '{base, 1'b0};
    vecs[2]  = '{mk(10'd100, 10'd50, 10'd500, 10'd56, 10'd110, 10'd400, 10'd520, 10'd410), 1'b0};
    vecs[3]  = '{mk(10'd100, 10'd50, 10'd500, 10'd60, 10'd110, 10'd400, 10'd524, 10'd410), 1'b0};
    vecs[4]  = '{base, 1'b0};
    vecs[5]  = '{base, 1'b0};
    vecs[6]  = '{base, 1'b0};
    vecs[7]  = '{base, 1'b0};
    vecs[8]  = '{base, 1'b1};
    vecs[9]  = '{mk(10'd104, 10'd50, 10'd500, 10'd60, 10'd110, 10'd400, 10'd520, 10'd410), 1'b1};
    vecs[10] = '{mk(10'd109, 10'd50, 10'd500, 10'd60, 10'd110, 10'd400, 10'd520, 10'd410), 1'b0};
    fa = mk(10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8);
    fb = mk(10'd900, 10'd800, 10'd700, 10'd600, 10'd500, 10'd400, 10'd300, 10'd200);
    fx = mk(10'd11, 10'd22, 10'd33, 10'd44, 10'd55, 10'd66, 10'd77, 10'd88);
    fy = {10'($urandom_range(200, 300)), 70'h12_3456_789a_bcde_f012};
    fz = ~fy;
    fw = mk(10'd1023, 10'd0, 10'd512, 10'd1, 10'd300, 10'd301, 10'd700, 10'd5);
    exp_fc = '0;

    // reset held: VS activity must not create output
    reset = 1'b0;
    enable = 1'b1;
    VGA_VS = 1'b0;
    out_ready = 1'b0;
    corners_in = base;
    for (int i = 0; i < 6; i++) begin
      VGA_VS = ~VGA_VS;
      tick();
    end
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_locked", 128'(locked), 128'(0));
    check("rst_overrun", 128'(overrun), 128'(0));
    check("rst_frame_count", 128'(frame_count), 128'(0));
    check("rst_corners_out", 128'(corners_out), 128'(0));
    enable = 1'b0;
    VGA_VS = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rst_state_idle", 128'(dbg_state), 128'(0));

    // lock-up table, including jitter +4 (held) and +5 (lost)
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back({vecs[i].exp_locked, vecs[i].c});
      do_frame(vecs[i].c);
      exp_fc++;
      check($sformatf("tbl_frame_count_%0d", i), 128'(frame_count), 128'(exp_fc));
      check($sformatf("tbl_locked_%0d", i), 128'(locked), 128'(vecs[i].exp_locked));
    end

    // overrun: two frames without a consumer
    out_ready = 1'b0;
    do_frame(fa);
    check("ovr_after_a", 128'(overrun), 128'(0));
    check("ovr_valid_a", 128'(out_valid), 128'(1));
    do_frame(fb);
    exp_fc += 2;
    check("ovr_set", 128'(overrun), 128'(1));
    check("ovr_corners_b", 128'(corners_out), 128'(fb));
    check("ovr_valid_b", 128'(out_valid), 128'(1));
    check("ovr_frame_count", 128'(frame_count), 128'(exp_fc));
    exp_q.push_back({1'b0, fb});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_drop", 128'(out_valid), 128'(0));
    check("ovr_sticky", 128'(overrun), 128'(1));

    // latency and capture point; corners_in changes at E+3 and E+4
    tick();
    out_ready = 1'b1;
    corners_in = fx;
    VGA_VS = 1'b1;
    tick();
    tick();
    VGA_VS = 1'b0;
    exp_q.push_back({1'b0, fy});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) corners_in = fy;
      if (c == 4) corners_in = fz;
      if (c == 5) begin
        @(negedge clk);
        check("lat_e5_low", 128'(out_valid), 128'(0));
      end
      if (c == 6) begin
        @(negedge clk);
        check("lat_e6_high", 128'(out_valid), 128'(1));
      end
    end
    repeat (3) tick();
    exp_fc++;

    // lock again on fw; last frame left pending
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, fw});
      do_frame(fw);
    end
    out_ready = 1'b0;
    do_frame(fw);
    exp_fc += 9;
    check("relock_locked", 128'(locked), 128'(1));
    check("relock_valid", 128'(out_valid), 128'(1));

    // disable during SETTLE
    VGA_VS = 1'b1;
    tick();
    tick();
    VGA_VS = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    @(negedge clk);
    check("dis_state", 128'(dbg_state), 128'(0));
    check("dis_valid", 128'(out_valid), 128'(0));
    check("dis_locked", 128'(locked), 128'(0));
    check("dis_overrun", 128'(overrun), 128'(0));
    check("dis_frame_count", 128'(frame_count), 128'(exp_fc));
    check("dis_corners_kept", 128'(corners_out), 128'(fw));

    // VS fall while disabled: nothing captured
    do_frame(fa);
    check("dis_vs_count", 128'(frame_count), 128'(exp_fc));
    check("dis_vs_valid", 128'(out_valid), 128'(0));
    check("dis_vs_corners", 128'(corners_out), 128'(fw));

    // re-enable: first frame starts stability from zero, lock on 9th
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({(i == 8) ? 1'b1 : 1'b0, fw});
      do_frame(fw);
    end
    exp_fc += 9;
    check("end_frame_count", 128'(frame_count), 128'(exp_fc));
    check("end_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
